// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and FSM state type for the 1R1W SRAM requester-side controller.
package sram_ctrl_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 1024;
  localparam int unsigned WIDTH_DEFAULT  = 12;
  localparam int unsigned ADDR_W_DEFAULT = 10;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_IDLE
  } state_e;

endpackage

// File: rtl/sram_init_sweeper.sv
// Init sweep address counter: restarts on reset/flush, steps while active, flags the last entry.
module sram_init_sweeper
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              active,
  output logic [ADDR_W-1:0] init_addr,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  // One spare bit so the count can reach DEPTH without wrapping back to 0.
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    init_cnt_d = init_cnt_q;
    if (flush) begin
      init_cnt_d = '0;
    end else if (active) begin
      init_cnt_d = init_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_addr = init_cnt_q[ADDR_W-1:0];
  assign done      = active && (init_cnt_q == LAST);

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Requester-side controller for a 1R1W SRAM macro: zero-fill sweep, posted writes, 1-cycle reads.
// Optional macro SRAM_HOLD_READ_EN keeps the last read value on r_resp_data between responses.
module sram_1r1w_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned      DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned      WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned      ADDR_W     = ADDR_W_DEFAULT,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              init_done,

  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  output logic [WIDTH-1:0]  r_resp_data,

  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [WIDTH-1:0]  w_req_data,

  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [WIDTH-1:0]  mem_r_data,

  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [WIDTH-1:0]  mem_w_data
);

  state_e            state_q, state_d;
  logic              in_init;
  logic              sweep_done;
  logic [ADDR_W-1:0] sweep_addr;
  logic              r_fire, w_fire;
  logic              resp_valid_q;
  logic              byp_q;
  logic [WIDTH-1:0]  byp_data_q;
  logic [WIDTH-1:0]  resp_data;

  assign in_init = (state_q == ST_INIT);

  sram_init_sweeper #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweeper (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .active    (in_init),
    .init_addr (sweep_addr),
    .done      (sweep_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (sweep_done) state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    // Flush wins in every state, including the last sweep cycle.
    if (flush) begin
      state_d = ST_INIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign init_done   = !in_init;
  assign r_req_ready = !in_init;
  assign w_req_ready = !in_init;

  assign r_fire = r_req_valid && r_req_ready;
  assign w_fire = w_req_valid && w_req_ready;

  assign mem_r_en   = r_fire;
  assign mem_r_addr = r_req_addr;

  always_comb begin
    mem_w_en   = w_fire;
    mem_w_addr = w_req_addr;
    mem_w_data = w_req_data;
    if (in_init) begin
      mem_w_en   = 1'b1;
      mem_w_addr = sweep_addr;
      mem_w_data = INIT_VALUE;
    end
  end

  // Write-first on a same-address collision: the macro may return stale data, so forward
  // the write data into the response instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      byp_q        <= 1'b0;
      byp_data_q   <= '0;
    end else begin
      resp_valid_q <= r_fire;
      byp_q        <= r_fire && w_fire && (r_req_addr == w_req_addr);
      byp_data_q   <= w_req_data;
    end
  end

  assign r_resp_valid = resp_valid_q;
  assign resp_data    = byp_q ? byp_data_q : mem_r_data;

`ifdef SRAM_HOLD_READ_EN
  logic [WIDTH-1:0] hold_q;

  // Not cleared by flush: the last returned value survives a re-init.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= '0;
    end else if (resp_valid_q) begin
      hold_q <= resp_data;
    end
  end

  assign r_resp_data = resp_valid_q ? resp_data : hold_q;
`else
  assign r_resp_data = resp_data;
`endif

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Self-checking bench for sram_1r1w_ctrl with a read-first macro model and a behavioural reference.
module tb_sram_1r1w_ctrl;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 12;
  localparam int ADDR_W = 10;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              init_done;
  logic              r_req_valid, r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_resp_valid;
  logic [WIDTH-1:0]  r_resp_data;
  logic              w_req_valid, w_req_ready;
  logic [ADDR_W-1:0] w_req_addr;
  logic [WIDTH-1:0]  w_req_data;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [WIDTH-1:0]  mem_r_data;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [WIDTH-1:0]  mem_w_data;

  int n_checks = 0;
  int n_errors = 0;

  sram_1r1w_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .init_done    (init_done),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_req_addr   (r_req_addr),
    .r_resp_valid (r_resp_valid),
    .r_resp_data  (r_resp_data),
    .w_req_valid  (w_req_valid),
    .w_req_ready  (w_req_ready),
    .w_req_addr   (w_req_addr),
    .w_req_data   (w_req_data),
    .mem_r_en     (mem_r_en),
    .mem_r_addr   (mem_r_addr),
    .mem_r_data   (mem_r_data),
    .mem_w_en     (mem_w_en),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-first macro; garbage on the read port when not reading.
  logic [WIDTH-1:0] macro_arr [DEPTH];
  always @(posedge clock) begin
    if (mem_r_en) mem_r_data <= macro_arr[mem_r_addr];
    else          mem_r_data <= WIDTH'($urandom);
    if (mem_w_en) macro_arr[mem_w_addr] <= mem_w_data;
  end

  // Reference: "since" counts cycles since reset/flush; the array is idle once it reaches DEPTH.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               since = 0;
  bit               model_on = 0;
  bit               pv = 0;
  logic [WIDTH-1:0] pd = '0;
  logic [WIDTH-1:0] last_resp = '0;

  always @(posedge clock) begin
    bit idle, rf, wf;
    if (reset) begin
      since = 0; pv = 0; last_resp = '0; model_on = 1;
    end else begin
      idle = (since >= DEPTH);
      rf = idle && r_req_valid;
      wf = idle && w_req_valid;
      pv = rf;
      if (rf) begin
        pd = (wf && w_req_addr == r_req_addr) ? w_req_data : ref_mem[r_req_addr];
        last_resp = pd;
      end
      if (!idle)   ref_mem[since] = '0;
      else if (wf) ref_mem[w_req_addr] = w_req_data;
      if (flush)              since = 0;
      else if (since < DEPTH) since++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit idle;
    idle = (since >= DEPTH);
    chk("init_done", 32'(init_done), 32'(idle));
    chk("r_req_ready", 32'(r_req_ready), 32'(idle));
    chk("w_req_ready", 32'(w_req_ready), 32'(idle));
    chk("mem_r_en", 32'(mem_r_en), 32'(idle && r_req_valid));
    if (idle && r_req_valid) chk("mem_r_addr", 32'(mem_r_addr), 32'(r_req_addr));
    chk("mem_w_en", 32'(mem_w_en), 32'(!idle || w_req_valid));
    if (!idle) begin
      chk("init_w_addr", 32'(mem_w_addr), 32'(since));
      chk("init_w_data", 32'(mem_w_data), 32'h0);
    end else if (w_req_valid) begin
      chk("mem_w_addr", 32'(mem_w_addr), 32'(w_req_addr));
      chk("mem_w_data", 32'(mem_w_data), 32'(w_req_data));
    end
    chk("r_resp_valid", 32'(r_resp_valid), 32'(pv));
    if (pv) chk("r_resp_data", 32'(r_resp_data), 32'(pd));
`ifdef SRAM_HOLD_READ_EN
    else chk("r_resp_hold", 32'(r_resp_data), 32'(last_resp));
`endif
  endtask

  always @(negedge clock) begin
    #2;
    if (model_on) compare();
  end

  task automatic drive(input bit rv, input logic [ADDR_W-1:0] ra, input bit wv,
                       input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd, input bit fl);
    @(negedge clock);
    r_req_valid = rv; r_req_addr = ra;
    w_req_valid = wv; w_req_addr = wa; w_req_data = wd;
    flush = fl;
  endtask

  task automatic idle_cycle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Called in the first cycle of a sweep; returns the cycle index at which init_done is seen.
  task automatic wait_init(output int n);
    n = 0;
    #1;
    while (!init_done && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [ADDR_W-1:0] a;
    reset = 1'b1; flush = 1'b0;
    r_req_valid = 1'b0; r_req_addr = '0;
    w_req_valid = 1'b0; w_req_addr = '0; w_req_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #3;
    chk("c0_w_en", 32'(mem_w_en), 32'h1);
    chk("c0_w_addr", 32'(mem_w_addr), 32'h0);
    chk("c0_ready", 32'(r_req_ready), 32'h0);
    wait_init(n);
    chk("reset_init_cycles", 32'(n), 32'd1024);

    // Write then read.
    drive(1'b0, '0, 1'b1, 10'd7, 12'h5A3, 1'b0);
    drive(1'b1, 10'd7, 1'b0, '0, '0, 1'b0);
    idle_cycle(); #3;
    chk("wr_rd_valid", 32'(r_resp_valid), 32'h1);
    chk("wr_rd_data", 32'(r_resp_data), 32'h5A3);

    // Same-cycle collision is write-first.
    drive(1'b1, 10'h3FF, 1'b1, 10'h3FF, 12'hABC, 1'b0);
    idle_cycle(); #3;
    chk("collide_data", 32'(r_resp_data), 32'hABC);

    // Read, then overwrite without reading.
    drive(1'b1, 10'd7, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 10'd7, 12'h111, 1'b0); #3;
    chk("rd7_data", 32'(r_resp_data), 32'h5A3);
    idle_cycle(); #3;
    chk("rd7_valid_drop", 32'(r_resp_valid), 32'h0);
`ifdef SRAM_HOLD_READ_EN
    chk("hold_after_write", 32'(r_resp_data), 32'h5A3);
`endif

    // Flush from IDLE clears the array.
    drive(1'b0, '0, 1'b1, 10'd7, 12'h5A3, 1'b0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle_cycle();
    wait_init(n);
    chk("flush_idle_cycles", 32'(n), 32'd1024);
    drive(1'b1, 10'd7, 1'b0, '0, '0, 1'b0);
    idle_cycle(); #3;
    chk("post_flush_data", 32'(r_resp_data), 32'h0);

    // Flush at sweep cycle 500 restarts the sweep.
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle_cycle();
    repeat (499) idle_cycle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1); #3;
    chk("sweep500_addr", 32'(mem_w_addr), 32'd500);
    idle_cycle(); #3;
    chk("restart_addr", 32'(mem_w_addr), 32'h0);
    wait_init(n);
    chk("flush_sweep_cycles", 32'(n), 32'd1024);

    // Random traffic with occasional flushes, concentrated on a few addresses.
    for (int i = 0; i < 4000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      r_req_addr = a;
      a = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      drive(1'($urandom), r_req_addr, 1'($urandom), a, 12'($urandom),
            ($urandom_range(0, 299) == 0));
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
